serial_subtractor: RTL and testbench

- Bit-serial, LSB-first WIDTH-bit subtractor computing a - b, built around one full-subtractor cell and a borrow flip-flop.
- Arithmetic counterpart to the combinational half adder: trades area for WIDTH cycles of latency.
- Uses a start/busy/done handshake so a sequencer or testbench can issue operands and collect difference and borrow.
- Also exposes a per-cycle serial bit stream for waveform debug.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b over WIDTH cycles using one
// full-subtractor cell and a borrow flop, with a start/busy/done handshake.
// Optional macro SERIAL_SUB_OVF_EN adds a registered two's-complement
// overflow flag (ovf) alongside diff.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             bit_valid,
  output logic             bit_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             br;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic             d_c;
  logic             nbr_c;
  logic             nxt_bit_c;
  logic [WIDTH-1:0] res_next_c;

  // Full-subtractor cell on the current LSBs plus the result after this shift
  assign d_c        = a_sh[0] ^ b_sh[0] ^ br;
  assign nbr_c      = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_next_c = {d_c, res_sh[WIDTH-1:1]};
  // Difference bit of the following cycle, so bit_out always shows the bit
  // being produced in the cycle it is presented
  assign nxt_bit_c  = a_sh[1] ^ b_sh[1] ^ nbr_c;

  // Sequencer, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh      <= a;
            b_sh      <= b;
            res_sh    <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            busy      <= 1'b1;
            bit_valid <= 1'b1;
            bit_out   <= a[0] ^ b[0];
`ifdef SERIAL_SUB_OVF_EN
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
`endif
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next_c;
          br     <= nbr_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            diff       <= res_next_c;
            borrow_out <= nbr_c;
            busy       <= 1'b0;
            done       <= 1'b1;
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= (a_msb != b_msb) && (d_c != a_msb);
`endif
            state      <= DONE;
          end else begin
            bit_out <= nxt_bit_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): arithmetic reference
// model compared every cycle, plus directed literal expectations.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, bit_valid, bit_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: m_k = index of bit being produced, -1 when not running
  int           m_k = -1;
  bit           m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  bit           m_borrow = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] oa = '0;
  logic [W-1:0] ob = '0;
  logic [W-1:0] md = '0;
  bit           chk_en = 1'b0;

  // Observation logs
  int           n_done = 0;
  int           done_last = 0;
  logic [W-1:0] bit_cap = '0;
  int           bit_n = 0;
  int           busy_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a - b with unsigned borrow and signed overflow, WIDTH cycles after accept
  always @(posedge clk) begin
    int sd;
    cyc++;
    if (!rst_n) begin
      m_k = -1; m_done = 0; m_diff = '0; m_borrow = 0; m_ovf = 0;
      chk_en = 1'b1;
    end else if (m_k >= 0) begin
      if (m_k == int'(W) - 1) begin
        m_diff   = oa - ob;
        m_borrow = (oa < ob);
        sd       = $signed(oa) - $signed(ob);
        m_ovf    = (sd > 127) || (sd < -128);
        m_done   = 1'b1;
        m_k      = -1;
      end else begin
        m_k++;
      end
    end else begin
      m_done = 1'b0;
      if (start === 1'b1) begin
        oa = a; ob = b; md = a - b;
        m_k = 0;
      end
    end
  end

  // Compare DUT against model on every cycle after the first reset edge
  always @(negedge clk) begin
    logic exp_busy, exp_bit;
    if (chk_en) begin
      exp_busy = (m_k >= 0);
      exp_bit  = exp_busy ? md[m_k] : 1'b0;
      chk("busy",       32'(busy),       32'(exp_busy));
      chk("done",       32'(done),       32'(m_done));
      chk("bit_valid",  32'(bit_valid),  32'(exp_busy));
      chk("bit_out",    32'(bit_out),    32'(exp_bit));
      chk("diff",       32'(diff),       32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf",        32'(ovf),        32'(m_ovf));
`endif
      if (bit_valid === 1'b1) begin
        bit_cap = {bit_out, bit_cap[W-1:1]};
        bit_n++;
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        n_done++;
        done_last = cyc;
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done timeout got 0 exp 1", name);
    end
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input string name);
    @(posedge clk);
    #2;
    a = ia; b = ib; start = 1'b1;
    bit_n = 0; busy_n = 0;
    @(posedge clk);
    #2;
    start = 1'b0;
    a = 8'h3C; b = 8'hC3;
    wait_done(name);
  endtask

  initial begin
    int d1, nd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_diff",   32'(diff),       32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_bitv",   32'(bit_valid),  32'd0);
    chk("rst_bito",   32'(bit_out),    32'd0);
    chk("rst_ndone",  32'(n_done),     32'd0);

    op(8'h05, 8'h03, "5-3");
    chk("5-3_diff",   32'(diff),       32'h02);
    chk("5-3_borrow", 32'(borrow_out), 32'd0);
    chk("5-3_bits",   32'(bit_cap),    32'h02);
    chk("5-3_nbits",  32'(bit_n),      32'd8);
    chk("5-3_nbusy",  32'(busy_n),     32'd8);

    op(8'h03, 8'h05, "3-5");
    chk("3-5_diff",   32'(diff),       32'hFE);
    chk("3-5_borrow", 32'(borrow_out), 32'd1);

    op(8'h00, 8'h01, "0-1");
    chk("0-1_diff",   32'(diff),       32'hFF);
    chk("0-1_borrow", 32'(borrow_out), 32'd1);

    // Back-to-back with start held high through done, plus ignored mid-shift starts
    @(posedge clk);
    #2;
    a = 8'h10; b = 8'h01; start = 1'b1;
    wait_done("b2b1");
    chk("b2b1_diff",   32'(diff),       32'h0F);
    chk("b2b1_borrow", 32'(borrow_out), 32'd0);
    d1 = done_last;
    a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #2;
    a = 8'h12; b = 8'h34;
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2;
    start = 1'b1; a = 8'h77; b = 8'h11;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done("b2b2");
    chk("b2b2_diff",   32'(diff),           32'h00);
    chk("b2b2_borrow", 32'(borrow_out),     32'd0);
    chk("b2b_gap",     32'(done_last - d1), 32'd9);
    nd = n_done;
    repeat (12) @(negedge clk);
    #1;
    chk("b2b_nomore",  32'(n_done - nd),    32'd0);

    // Abort with reset on the 4th shift cycle
    @(posedge clk);
    #2;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    nd = n_done;
    repeat (15) @(negedge clk);
    #1;
    chk("abort_ndone", 32'(n_done - nd), 32'd0);
    chk("abort_diff",  32'(diff),        32'd0);
    chk("abort_busy",  32'(busy),        32'd0);

    op(8'hAA, 8'h55, "AA-55");
    chk("AA-55_diff",   32'(diff),       32'h55);
    chk("AA-55_borrow", 32'(borrow_out), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    op(8'h80, 8'h01, "80-01");
    chk("80-01_diff", 32'(diff), 32'h7F);
    chk("80-01_ovf",  32'(ovf),  32'd1);
    op(8'h7F, 8'hFF, "7F-FF");
    chk("7F-FF_diff",   32'(diff),       32'h80);
    chk("7F-FF_ovf",    32'(ovf),        32'd1);
    chk("7F-FF_borrow", 32'(borrow_out), 32'd1);
    op(8'h05, 8'h03, "ovf5-3");
    chk("5-3_ovf", 32'(ovf), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
